// File: rtl/voice_allocator_if.sv
// Note-request channel into the voice allocator: the requester holds
// req_valid and the req_on/key/vel payload; the allocator answers with req_ready.
interface voice_allocator_if;
  // Handshake: a request transfers on a rising clock edge where req_valid and
  // req_ready are both high; the payload must stay stable while req_valid is high.
  logic       req_valid;
  logic       req_ready;
  logic       req_on;
  logic [7:0] req_key;
  logic [7:0] req_vel;

  modport master (output req_valid, req_on, req_key, req_vel, input req_ready);
  modport slave  (input req_valid, req_on, req_key, req_vel, output req_ready);
endinterface

// File: rtl/voice_allocator.sv
// Maps note-on/off requests onto synth voice slots: retrigger a held key,
// else take a free voice, else steal the oldest one.
module voice_allocator #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               OSC_CLK,
  input  logic               reset_reg_N,
  voice_allocator_if.slave   req,
  input  logic [VOICES-1:0]  voice_free,
  output logic               note_on,
  output logic               note_off,
  output logic               stolen,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic [VOICES-1:0]  keys_on,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, ISSUE = 2'd2} state_t;

  state_t             state;
  logic [V_WIDTH-1:0] rr_ptr;
  logic [V_WIDTH-1:0] scan_i;
  logic [V_WIDTH-1:0] scan_v;
  logic [V_WIDTH:0]   scan_sum;
  logic [7:0]         age [VOICES];
  logic [7:0]         key [VOICES];
  logic               lat_on;
  logic [7:0]         lat_key;
  logic [7:0]         lat_vel;
  logic               match_found;
  logic               free_found;
  logic [V_WIDTH-1:0] match_idx;
  logic [V_WIDTH-1:0] free_idx;
  logic [V_WIDTH-1:0] old_idx;
  logic [7:0]         old_age;
  logic [V_WIDTH-1:0] alloc_idx;

  assign fsm_state = state;

  // Scan order starts at the round-robin pointer and wraps modulo VOICES.
  always_comb begin
    scan_sum = {1'b0, rr_ptr} + {1'b0, scan_i};
    if (scan_sum >= (V_WIDTH+1)'(VOICES))
      scan_sum = scan_sum - (V_WIDTH+1)'(VOICES);
    scan_v = scan_sum[V_WIDTH-1:0];
  end

  always_comb begin
    alloc_idx = old_idx;
    if (match_found)     alloc_idx = match_idx;
    else if (free_found) alloc_idx = free_idx;
  end

  function automatic logic [V_WIDTH-1:0] next_v(input logic [V_WIDTH-1:0] x);
    return (x == V_WIDTH'(VOICES-1)) ? '0 : x + 1'b1;
  endfunction

  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state         <= IDLE;
      req.req_ready <= 1'b1;
      keys_on       <= '0;
      note_on       <= 1'b0;
      note_off      <= 1'b0;
      stolen        <= 1'b0;
      cur_key_adr   <= '0;
      cur_key_val   <= '0;
      cur_vel_on    <= '0;
      cur_vel_off   <= '0;
      rr_ptr        <= '0;
      scan_i        <= '0;
      lat_on        <= 1'b0;
      lat_key       <= '0;
      lat_vel       <= '0;
      match_found   <= 1'b0;
      free_found    <= 1'b0;
      match_idx     <= '0;
      free_idx      <= '0;
      old_idx       <= '0;
      old_age       <= '0;
      for (int v = 0; v < VOICES; v++) begin
        age[v] <= '0;
        key[v] <= '0;
      end
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      stolen   <= 1'b0;
      case (state)
        IDLE: begin
          // ready returns one cycle after ISSUE, so the pulse cycle never accepts
          if (req.req_valid && req.req_ready) begin
            lat_on        <= req.req_on;
            lat_key       <= req.req_key;
            lat_vel       <= req.req_vel;
            req.req_ready <= 1'b0;
            scan_i        <= '0;
            match_found   <= 1'b0;
            free_found    <= 1'b0;
            state         <= SCAN;
          end else begin
            req.req_ready <= 1'b1;
          end
        end
        SCAN: begin
          if (!match_found && keys_on[scan_v] && key[scan_v] == lat_key) begin
            match_found <= 1'b1;
            match_idx   <= scan_v;
          end
          if (!free_found && voice_free[scan_v] && !keys_on[scan_v]) begin
            free_found <= 1'b1;
            free_idx   <= scan_v;
          end
          // strict compare keeps the earlier-scanned voice on an age tie
          if (scan_i == '0 || age[scan_v] > old_age) begin
            old_idx <= scan_v;
            old_age <= age[scan_v];
          end
          if (scan_i == V_WIDTH'(VOICES-1)) state <= ISSUE;
          scan_i <= scan_i + 1'b1;
        end
        ISSUE: begin
          state <= IDLE;
          if (lat_on) begin
            if (!match_found) begin
              rr_ptr <= next_v(alloc_idx);
              stolen <= !free_found;
              for (int v = 0; v < VOICES; v++)
                if (age[v] != 8'hFF) age[v] <= age[v] + 8'd1;
              age[alloc_idx] <= '0;
            end
            key[alloc_idx]     <= lat_key;
            keys_on[alloc_idx] <= 1'b1;
            note_on            <= 1'b1;
            cur_key_adr        <= alloc_idx;
            cur_key_val        <= lat_key;
            cur_vel_on         <= lat_vel;
          end else if (match_found) begin
            keys_on[match_idx] <= 1'b0;
            note_off           <= 1'b1;
            cur_key_adr        <= match_idx;
            cur_key_val        <= lat_key;
            cur_vel_off        <= lat_vel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random note traffic,
// checked every cycle against a voice-table model of the allocation rules.
module tb_voice_allocator;
  localparam int NV = 8;
  localparam int W  = 14;

  logic          osc_clk;
  logic          reset_n;
  logic [NV-1:0] vf;
  logic          note_on, note_off, stolen;
  logic [2:0]    cur_key_adr;
  logic [7:0]    cur_key_val, cur_vel_on, cur_vel_off;
  logic [NV-1:0] keys_on;
  logic [1:0]    fsm_state;

  voice_allocator_if ifc ();

  voice_allocator #(.VOICES(NV), .V_WIDTH(3)) dut (
    .OSC_CLK(osc_clk), .reset_reg_N(reset_n), .req(ifc.slave),
    .voice_free(vf), .note_on(note_on), .note_off(note_off), .stolen(stolen),
    .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
    .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off),
    .keys_on(keys_on), .fsm_state(fsm_state)
  );

  // clock / reset
  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  int cyc = 0;
  always @(posedge osc_clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // reference model: voice table
  bit        m_on  [NV];
  bit [7:0]  m_key [NV];
  int        m_age [NV];
  int        m_rr;
  logic [NV-1:0] exp_keys;
  logic      exp_ready, exp_non, exp_noff, exp_st;
  logic [2:0] exp_adr;
  logic [7:0] exp_key, exp_von, exp_voff;
  logic [W-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  int pulse_cnt = 0, last_lat = 0, last_low = 0, low_run = 0, acc_cyc = 0;
  logic last_stolen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int v = 0; v < NV; v++) begin
      m_on[v] = 0; m_key[v] = 0; m_age[v] = 0;
    end
    m_rr = 0; exp_keys = '0; exp_ready = 1'b1;
    exp_non = 0; exp_noff = 0; exp_st = 0;
    exp_adr = 0; exp_key = 0; exp_von = 0; exp_voff = 0;
    exp_q.delete();
  endtask

  // applies one request to the voice table at the moment the DUT issues it
  task automatic model_issue(input bit on, input bit [7:0] k, input bit [7:0] vel);
    int mv = -1, fv = -1, ov = -1, v, alloc;
    bit st = 0;
    for (int j = 0; j < NV; j++) begin
      v = (m_rr + j) % NV;
      if (mv < 0 && m_on[v] && m_key[v] == k) mv = v;
      if (fv < 0 && vf[v] && !m_on[v]) fv = v;
      if (ov < 0 || m_age[v] > m_age[ov]) ov = v;
    end
    if (on) begin
      if (mv >= 0) alloc = mv;
      else begin
        alloc = (fv >= 0) ? fv : ov;
        st = (fv < 0);
        m_rr = (alloc + 1) % NV;
        for (int u = 0; u < NV; u++) if (m_age[u] < 255) m_age[u]++;
        m_age[alloc] = 0;
      end
      m_key[alloc] = k; m_on[alloc] = 1;
      exp_non = 1; exp_st = st; exp_adr = 3'(alloc); exp_key = k; exp_von = vel;
      exp_q.push_back({1'b1, 1'b0, st, 3'(alloc), k});
    end else if (mv >= 0) begin
      m_on[mv] = 0;
      exp_noff = 1; exp_adr = 3'(mv); exp_key = k; exp_voff = vel;
      exp_q.push_back({1'b0, 1'b1, 1'b0, 3'(mv), k});
    end
    for (int u = 0; u < NV; u++) exp_keys[u] = m_on[u];
  endtask

  // driver
  task automatic send(input bit on, input bit [7:0] k, input bit [7:0] vel);
    int n = 0;
    @(negedge osc_clk);
    ifc.req_valid = 1'b1; ifc.req_on = on; ifc.req_key = k; ifc.req_vel = vel;
    while (!ifc.req_ready && n < 20) begin
      @(negedge osc_clk);
      n++;
    end
    if (n >= 20) chk("ready_wait", 32'(n), 32'd0);
    @(posedge osc_clk); #1;
    acc_cyc = cyc; exp_ready = 1'b0; ifc.req_valid = 1'b0;
    repeat (NV + 1) @(posedge osc_clk);
    #1 model_issue(on, k, vel);
    @(posedge osc_clk); #1;
    exp_non = 0; exp_noff = 0; exp_st = 0; exp_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge osc_clk); #2;
    reset_n = 1'b0; mreset();
    repeat (2) @(posedge osc_clk);
    #2 reset_n = 1'b1;
  endtask

  // scoreboard / per-cycle compare
  always @(negedge osc_clk) begin
    if (chk_en) begin
      logic [W-1:0] e;
      chk("keys_on", 32'(keys_on), 32'(exp_keys));
      chk("req_ready", 32'(ifc.req_ready), 32'(exp_ready));
      chk("note_on", 32'(note_on), 32'(exp_non));
      chk("note_off", 32'(note_off), 32'(exp_noff));
      chk("stolen", 32'(stolen), 32'(exp_st));
      chk("cur_key_adr", 32'(cur_key_adr), 32'(exp_adr));
      chk("cur_key_val", 32'(cur_key_val), 32'(exp_key));
      chk("cur_vel_on", 32'(cur_vel_on), 32'(exp_von));
      chk("cur_vel_off", 32'(cur_vel_off), 32'(exp_voff));
      if (note_on || note_off) begin
        pulse_cnt++;
        last_stolen = stolen;
        last_lat = cyc - acc_cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected act=%0b%0b exp=none", note_on, note_off);
        end else begin
          e = exp_q.pop_front();
          total--;
          chk("sb_event", 32'({note_on, note_off, stolen, cur_key_adr, cur_key_val}), 32'(e));
        end
      end
      if (!ifc.req_ready) low_run++;
      else if (low_run != 0) begin
        last_low = low_run;
        low_run = 0;
      end
    end
  end

  // stimulus
  initial begin
    int pcnt;
    reset_n = 1'b0; vf = 8'hFF;
    ifc.req_valid = 1'b0; ifc.req_on = 1'b0; ifc.req_key = '0; ifc.req_vel = '0;
    mreset();
    repeat (3) @(posedge osc_clk);
    #2 reset_n = 1'b1;
    chk_en = 1;
    @(negedge osc_clk); #1;
    chk("rst_ready", 32'(ifc.req_ready), 32'd1);
    chk("rst_keys", 32'(keys_on), 32'd0);
    chk("rst_adr", 32'(cur_key_adr), 32'd0);

    // 1: first note lands on voice 0
    send(1, 8'd60, 8'd100);
    @(negedge osc_clk); #1;
    chk("t1_latency", 32'(last_lat), 32'd9);
    chk("t1_adr", 32'(cur_key_adr), 32'd0);
    chk("t1_key", 32'(cur_key_val), 32'd60);
    chk("t1_vel", 32'(cur_vel_on), 32'd100);
    chk("t1_keys", 32'(keys_on), 32'h01);
    chk("t1_stolen", 32'(last_stolen), 32'd0);
    chk("t1_ready_low", 32'(last_low), 32'd10);

    // 2: second voice, then release the first
    send(1, 8'd64, 8'd90);
    chk("t2_on_adr", 32'(cur_key_adr), 32'd1);
    chk("t2_on_keys", 32'(keys_on), 32'h03);
    send(0, 8'd60, 8'd40);
    chk("t2_off_adr", 32'(cur_key_adr), 32'd0);
    chk("t2_off_vel", 32'(cur_vel_off), 32'd40);
    chk("t2_off_keys", 32'(keys_on), 32'h02);

    // 3: retrigger a held key
    send(1, 8'd64, 8'd77);
    chk("t3_adr", 32'(cur_key_adr), 32'd1);
    chk("t3_keys", 32'(keys_on), 32'h02);
    chk("t3_stolen", 32'(last_stolen), 32'd0);
    chk("t3_model_rr", 32'(m_rr), 32'd2);

    // 4: fill all voices, then steal the oldest
    do_reset();
    for (int k = 60; k < 68; k++) send(1, 8'(k), 8'd50);
    vf = 8'h00;
    send(1, 8'd70, 8'd33);
    chk("t4_adr", 32'(cur_key_adr), 32'd0);
    chk("t4_stolen", 32'(last_stolen), 32'd1);
    chk("t4_key", 32'(cur_key_val), 32'd70);
    chk("t4_keys", 32'(keys_on), 32'hFF);

    // 5: release of a key that is not held
    pcnt = pulse_cnt;
    send(0, 8'd99, 8'd5);
    @(negedge osc_clk); #1;
    chk("t5_no_pulse", 32'(pulse_cnt), 32'(pcnt));
    chk("t5_keys", 32'(keys_on), 32'hFF);
    chk("t5_ready_low", 32'(last_low), 32'd10);
    chk("t5_ready", 32'(ifc.req_ready), 32'd1);

    // 6: reset in the middle of a scan
    vf = 8'hFF;
    pcnt = pulse_cnt;
    @(negedge osc_clk);
    ifc.req_valid = 1'b1; ifc.req_on = 1'b1; ifc.req_key = 8'd50; ifc.req_vel = 8'd9;
    @(posedge osc_clk); #1;
    acc_cyc = cyc; exp_ready = 1'b0; ifc.req_valid = 1'b0;
    repeat (3) @(posedge osc_clk);
    #2 reset_n = 1'b0; mreset();
    #1 chk("t6_ready_now", 32'(ifc.req_ready), 32'd1);
    repeat (2) @(posedge osc_clk);
    #2 reset_n = 1'b1;
    repeat (12) @(posedge osc_clk);
    #1;
    chk("t6_no_pulse", 32'(pulse_cnt), 32'(pcnt));
    chk("t6_keys", 32'(keys_on), 32'h00);

    // random traffic
    for (int n = 0; n < 250; n++) begin
      vf = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge osc_clk);
      send(($urandom_range(0, 9) < 7), 8'(60 + $urandom_range(0, 11)), 8'($urandom));
    end

    repeat (3) @(posedge osc_clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
